// File: rtl/hilo_muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit producing the HI/LO register pair.
// One radix-2 step per cycle; fixed latency regardless of operation or operands.
module hilo_muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [1:0]        Op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              Busy,
    output logic              Done,
    output logic              HiLoWrite,
    output logic              DivByZero,
    output logic [DATA_W-1:0] HI_out,
    output logic [DATA_W-1:0] LO_out
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  is_div_q, is_div_d;
    logic                  neg_res_q, neg_res_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  dbz_q, dbz_d;
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]     opb_q, opb_d;
    logic [DATA_W-1:0]     hi_q, hi_d;
    logic [DATA_W-1:0]     lo_q, lo_d;

    logic                  signed_op;
    logic                  sgn_a, sgn_b;
    logic [DATA_W:0]       mul_sum;
    logic [DATA_W:0]       div_shift;
    logic [DATA_W+1:0]     div_diff;
    logic [2*DATA_W-1:0]   prod_fixed;
    logic [DATA_W-1:0]     quot_fixed, rem_fixed;

    // ---------------- State register ----------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- Next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (Start) state_d = S_RUN;
            S_RUN:  if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- Output logic ----------------
    always_comb begin
        Busy      = (state_q != S_IDLE);
        Done      = (state_q == S_DONE);
        HiLoWrite = (state_q == S_DONE);
        DivByZero = (state_q == S_DONE) && dbz_q;
    end

    assign HI_out = hi_q;
    assign LO_out = lo_q;

    // ---------------- Datapath ----------------
    assign signed_op = ~Op[0];
    assign sgn_a     = signed_op & A[DATA_W-1];
    assign sgn_b     = signed_op & B[DATA_W-1];

    assign mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opb_q};

    // Sign fix-up; a zero divisor forces an all-ones quotient while the
    // remainder path already reproduces the latched dividend.
    assign prod_fixed = neg_res_q ? -acc_q : acc_q;
    assign quot_fixed = dbz_q ? '1
                      : (neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0]);
    assign rem_fixed  = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    is_div_d  = Op[1];
                    neg_res_d = sgn_a ^ sgn_b;
                    neg_rem_d = sgn_a;
                    dbz_d     = Op[1] && (B == '0);
                    acc_d     = {{DATA_W{1'b0}}, (sgn_a ? -A : A)};
                    opb_d     = sgn_b ? -B : B;
                    cnt_d     = CNT_W'(DATA_W - 1);
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    if (!div_diff[DATA_W+1]) begin
                        acc_d = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                    end else begin
                        acc_d = {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[DATA_W-1:1]};
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fixed;
                    lo_d = quot_fixed;
                end else begin
                    hi_d = prod_fixed[2*DATA_W-1:DATA_W];
                    lo_d = prod_fixed[DATA_W-1:0];
                end
            end
            default: ;
        endcase
    end

    // NOTE: the datapath registers are reset too, so an aborted operation
    // leaves no stale operands or results behind.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            acc_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule
